// File: rtl/core_types_pkg.sv
// Shared core types: machine word, instruction-queue entry and queue depth.
package core_types_pkg;

   localparam int IQ_DEPTH_DEFAULT = 4;

   typedef logic [31:0] word_t;

   // One buffered fetch: instruction, its PC and the prediction fetch acted on.
   typedef struct packed {
      word_t instr;
      word_t pc;
      logic  pred_taken;
      word_t pred_npc;
   } iq_entry_t;

endpackage

// File: rtl/instr_queue_if.sv
// Fetch-side and dispatch-side signals of the instruction queue.
// master = the fetch/dispatch/backend side, slave = the queue itself.
interface instr_queue_if
   import core_types_pkg::*;
#(
   parameter int IQ_DEPTH = IQ_DEPTH_DEFAULT
);
   localparam int PTR_W = $clog2(IQ_DEPTH) + 1;

   logic             flush;
   logic             fetch_valid;
   word_t            fetch_instr;
   word_t            fetch_pc;
   logic             fetch_pred_taken;
   word_t            fetch_pred_npc;
   logic             iq_full;
   logic             iq_empty;
   logic [PTR_W-1:0] iq_count;
   logic             dispatch_valid;
   word_t            dispatch_instr;
   word_t            dispatch_pc;
   logic             dispatch_pred_taken;
   word_t            dispatch_pred_npc;
   logic             dispatch_ready;

   modport master (
      output flush, fetch_valid, fetch_instr, fetch_pc, fetch_pred_taken,
             fetch_pred_npc, dispatch_ready,
      input  iq_full, iq_empty, iq_count, dispatch_valid, dispatch_instr,
             dispatch_pc, dispatch_pred_taken, dispatch_pred_npc
   );

   modport slave (
      input  flush, fetch_valid, fetch_instr, fetch_pc, fetch_pred_taken,
             fetch_pred_npc, dispatch_ready,
      output iq_full, iq_empty, iq_count, dispatch_valid, dispatch_instr,
             dispatch_pc, dispatch_pred_taken, dispatch_pred_npc
   );

endinterface

// File: rtl/instr_queue.sv
// Decoupling FIFO between fetch and dispatch with single-cycle flush.
// Status flags derive only from registered pointers; the head entry is read
// combinationally from storage, so no input reaches an output in one cycle.
module instr_queue
   import core_types_pkg::*;
#(
   parameter int IQ_DEPTH = IQ_DEPTH_DEFAULT
) (
   input  logic          CLK,
   input  logic          RST,
   instr_queue_if.slave  iq
);
   localparam int IDX_W = $clog2(IQ_DEPTH);
   localparam int PTR_W = IDX_W + 1;

   // Pointer MSB is the wrap bit; the low bits index storage.
   logic [PTR_W-1:0] head_reg;
   logic [PTR_W-1:0] tail_reg;
   iq_entry_t        entry_reg [IQ_DEPTH];

   logic [IDX_W-1:0]    head_idx;
   logic [IDX_W-1:0]    tail_idx;
   logic                empty;
   logic                full;
   logic                enq;
   logic                deq;
   logic [IQ_DEPTH-1:0] wr_en;
   iq_entry_t           wr_entry;
   iq_entry_t           head_entry;

   assign head_idx = head_reg[IDX_W-1:0];
   assign tail_idx = tail_reg[IDX_W-1:0];
   assign empty    = (head_reg == tail_reg);
   assign full     = (head_idx == tail_idx) && (head_reg[PTR_W-1] != tail_reg[PTR_W-1]);

   // Full is registered: a dequeue in the same cycle does not free a slot for fetch.
   assign enq = iq.fetch_valid && !full;
   assign deq = !empty && iq.dispatch_ready;

   assign wr_entry = '{instr:      iq.fetch_instr,
                       pc:         iq.fetch_pc,
                       pred_taken: iq.fetch_pred_taken,
                       pred_npc:   iq.fetch_pred_npc};

   // A flush drops the entry fetch presents in the same cycle.
   generate
      for (genvar gi = 0; gi < IQ_DEPTH; gi++) begin : g_wr_en
         assign wr_en[gi] = enq && !iq.flush && (tail_idx == IDX_W'(gi));
      end
   endgenerate

   // Pointer update: reset beats flush, flush beats enqueue/dequeue.
   always_ff @(posedge CLK) begin
      if (RST) begin
         head_reg <= '0;
         tail_reg <= '0;
      end else if (iq.flush) begin
         head_reg <= '0;
         tail_reg <= '0;
      end else begin
         if (enq) tail_reg <= tail_reg + PTR_W'(1);
         if (deq) head_reg <= head_reg + PTR_W'(1);
      end
   end

   // Entry storage: cleared only by reset, never by flush.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
         if (RST)           entry_reg[i] <= '0;
         else if (wr_en[i]) entry_reg[i] <= wr_entry;
      end
   end

   assign head_entry = entry_reg[head_idx];

   assign iq.iq_empty            = empty;
   assign iq.iq_full             = full;
   assign iq.iq_count            = tail_reg - head_reg;
   assign iq.dispatch_valid      = !empty;
   assign iq.dispatch_instr      = head_entry.instr;
   assign iq.dispatch_pc         = head_entry.pc;
   assign iq.dispatch_pred_taken = head_entry.pred_taken;
   assign iq.dispatch_pred_npc   = head_entry.pred_npc;

endmodule

// File: doc/instr_queue.md
# instr_queue

Decoupling FIFO between the fetch unit and dispatch. It buffers each fetched instruction together with its PC and branch-prediction metadata, so that icache/fetch bubbles and dispatch stalls do not propagate to each other. On a pipeline flush (mispredict or exception restore) it discards every queued entry in one cycle. It sits directly downstream of fetch_unit and directly upstream of dispatch.

## Interface

- IQ_DEPTH, 4, number of entries; power of two, ≥2
- CLK  in  1  core clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- flush  in  1  discard all entries this cycle (backend restore)
- fetch_valid  in  1  fetch presents an instruction this cycle
- fetch_instr  in  32  instruction word
- fetch_pc  in  32  PC of instruction
- fetch_pred_taken  in  1  fetch predicted taken (BTB/DIRP/RAS/jump)
- fetch_pred_npc  in  32  PC fetch proceeded to after this instruction
- iq_full  out  1  no free entry; fetch must hold its instruction
- iq_empty  out  1  no valid entry
- iq_count  out  $clog2(IQ_DEPTH)+1  occupancy
- dispatch_valid  out  1  head entry valid
- dispatch_instr / dispatch_pc / dispatch_pred_taken / dispatch_pred_npc  out  32/32/1/32  head entry fields
- dispatch_ready  in  1  dispatch consumes head this cycle

## Operation

- Storage: IQ_DEPTH entries of iq_entry_t; head_ptr, tail_ptr of $clog2(IQ_DEPTH)+1 bits (MSB = wrap bit).
- iq_empty = (head_ptr == tail_ptr); iq_full = index bits equal, wrap bits differ; iq_count = tail_ptr − head_ptr (mod 2^width). All three are functions of registered pointers only.
- Enqueue fires when fetch_valid && !iq_full: the entry is written at tail index, and tail_ptr increments.
- Dequeue fires when dispatch_valid && dispatch_ready: head_ptr increments. dispatch_ready is ignored when the queue is empty.
- dispatch_valid = !iq_empty; dispatch_* fields are read combinationally from the head index.
- Pointers wrap naturally through the index bits. The wrap bit toggles on wrap.
- Simultaneous enqueue and dequeue when neither full nor empty: both fire, and count is unchanged.
- Full queue with dispatch_ready=1: the dequeue fires, but the enqueue is rejected (iq_full is registered, with no same-cycle bypass). Fetch retries next cycle.
- Empty queue with fetch_valid=1: the enqueue fires, but dispatch_valid stays 0 this cycle (no fetch→dispatch bypass).
- flush=1: head_ptr and tail_ptr are both set to 0 next cycle. Flush has priority over enqueue and dequeue in the same cycle, and the entry presented by fetch that cycle is dropped. Entry data is not cleared.
- RST=1: pointers are set to 0 and all entry storage is set to 0. RST has priority over flush.

## Timing

- Reset values: iq_empty=1, iq_full=0, iq_count=0, dispatch_valid=0, dispatch_* fields=0.
- Enqueue to visible at head: 1 cycle (written at edge N, dispatch_valid at N+1 if the queue was empty).
- Flush to empty: 1 cycle. iq_full drops in the cycle after the flush.
- Throughput: 1 enqueue + 1 dequeue per cycle.
- iq_full, iq_empty and iq_count change only on clock edges.
- Combinational path runs from head_ptr to the dispatch_* outputs only. No input-to-output combinational paths.

## Structure

- core_types_pkg holds: word_t (32-bit logic), iq_entry_t (packed struct: instr, pc, pred_taken, pred_npc), and the IQ_DEPTH default constant.
- Single module; no sub-module.
- Pointer width is computed locally as $clog2(IQ_DEPTH)+1.

## Test plan

- Reset, then fill: hold RST 2 cycles, then enqueue pc 0x0, 0x4, 0x8, 0xC with dispatch_ready=0. Required: iq_count 1→4, iq_full=1 after the 4th, a 5th (pc 0x10) is rejected, and dispatch_pc=0x0 throughout.
- Drain order: from full, dispatch_ready=1 for 4 cycles. Required: dispatch_pc sequence 0x0, 0x4, 0x8, 0xC, then dispatch_valid=0 and iq_empty=1.
- Steady stream with wrap: enqueue and dequeue every cycle for 10 instructions starting at pc 0x100. Required: dispatch_pc increments by 4 in order, iq_count stays at 1 after the first fill, and pointers wrap past index 3 correctly.
- Full + dequeue same cycle: queue full, fetch_valid=1 (pc 0x20) with dispatch_ready=1. Required: head dequeued, pc 0x20 not written, iq_count=3 next cycle; on retry, pc 0x20 is accepted.
- Flush priority: 3 entries held, then flush=1 with fetch_valid=1 and dispatch_ready=1 in the same cycle. Required next cycle: iq_count=0, dispatch_valid=0, and the fetch entry is absent; pc 0x40 enqueued next appears at head.
- Reset mid-operation: 2 entries queued, RST=1 with flush=0 and fetch_valid=1. Required next cycle: all outputs at reset values and dispatch fields equal to 0.
